// File: rtl/gnn_part_pkg.sv
// Shared constants and types for the graph-partition pipeline (S1/S2/S3 calculation
// and dispatch blocks).
package gnn_part_pkg;

  localparam int ID_W         = 12;
  localparam int CORE_W       = 6;
  localparam int LOG2_VPC     = 5;
  localparam int NUM_VERTICES = 3703;

  // Dataset sizes used by the S1/S2/S3 partition calculations
  localparam int DS_NUM_NODES = 3703;
  localparam int DS_PART_SIZE = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/s3_id_gen.sv
// Combinational vertex-ID adder and limit comparator for the stage-3 dispatcher.
// The sum is formed wide so the limit check sees the true ID before truncation.
module s3_id_gen
  import gnn_part_pkg::*;
(
  input  logic [ID_W-1:0]     base_i,
  input  logic [CORE_W-1:0]   core_idx_i,
  input  logic [LOG2_VPC-1:0] offset_i,
  input  logic [CORE_W-1:0]   core_cnt_i,
  output logic [ID_W-1:0]     id_o,
  output logic                core_last_o,
  output logic                last_o
);

  localparam int FW = ID_W + CORE_W + 1;

  logic [FW-1:0]     full_id;
  logic [CORE_W-1:0] cnt_m1;
  logic              off_max;
  logic              at_limit;

  assign full_id  = FW'(base_i) + (FW'(core_idx_i) << LOG2_VPC) + FW'(offset_i);
  assign cnt_m1   = core_cnt_i - CORE_W'(1);
  assign off_max  = (offset_i == {LOG2_VPC{1'b1}});
  assign at_limit = (full_id == FW'(NUM_VERTICES - 1));

  assign id_o        = full_id[ID_W-1:0];
  assign core_last_o = off_max | at_limit;
  assign last_o      = ((core_idx_i == cnt_m1) & off_max) | at_limit;

endmodule

// File: rtl/s3_vertex_dispatcher.sv
// Stage-3 vertex dispatcher: walks base_ID + core*32 + offset for core_cnt cores,
// clipped at NUM_VERTICES, emitting one registered beat per handshake.
module s3_vertex_dispatcher
  import gnn_part_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ID_W-1:0]   base_ID,
  input  logic [CORE_W-1:0] core_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_ID,
  output logic [CORE_W-1:0] out_core,
  output logic              out_core_last,
  output logic              out_last,
  output logic              done,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     base_q, base_d;
  logic [CORE_W-1:0]   cnt_q, cnt_d;
  logic [CORE_W-1:0]   core_idx_q, core_idx_d;
  logic [LOG2_VPC-1:0] offset_q, offset_d;
  logic                load;

  logic                start_ready_q, out_valid_q, done_q, busy_q;
  logic [ID_W-1:0]     out_id_q;
  logic [CORE_W-1:0]   out_core_q;
  logic                out_core_last_q, out_last_q;

  logic [ID_W-1:0]     gen_id;
  logic                gen_core_last, gen_last;

  // The generator sees next-state counters so the output registers load the
  // upcoming beat in the same cycle the counters advance.
  s3_id_gen u_id_gen (
    .base_i      (base_d),
    .core_idx_i  (core_idx_d),
    .offset_i    (offset_d),
    .core_cnt_i  (cnt_d),
    .id_o        (gen_id),
    .core_last_o (gen_core_last),
    .last_o      (gen_last)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    core_idx_d = core_idx_q;
    offset_d   = offset_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          base_d     = base_ID;
          cnt_d      = core_cnt;
          core_idx_d = '0;
          offset_d   = '0;
          if (core_cnt == '0 || {1'b0, base_ID} >= (ID_W + 1)'(NUM_VERTICES)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            load = 1'b1;
            if (offset_q == {LOG2_VPC{1'b1}}) begin
              offset_d   = '0;
              core_idx_d = core_idx_q + CORE_W'(1);
            end else begin
              offset_d = offset_q + LOG2_VPC'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      base_q          <= '0;
      cnt_q           <= '0;
      core_idx_q      <= '0;
      offset_q        <= '0;
      start_ready_q   <= 1'b1;
      out_valid_q     <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      out_id_q        <= '0;
      out_core_q      <= '0;
      out_core_last_q <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      core_idx_q    <= core_idx_d;
      offset_q      <= offset_d;
      start_ready_q <= (state_d == IDLE);
      out_valid_q   <= (state_d == RUN);
      done_q        <= (state_d == DONE);
      busy_q        <= (state_d != IDLE);
      if (load) begin
        out_id_q        <= gen_id;
        out_core_q      <= core_idx_d;
        out_core_last_q <= gen_core_last;
        out_last_q      <= gen_last;
      end else if (state_d != RUN) begin
        out_core_last_q <= 1'b0;
        out_last_q      <= 1'b0;
      end
    end
  end

  assign start_ready   = start_ready_q;
  assign out_valid     = out_valid_q;
  assign out_ID        = out_id_q;
  assign out_core      = out_core_q;
  assign out_core_last = out_core_last_q;
  assign out_last      = out_last_q;
  assign done          = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_s3_vertex_dispatcher.sv
// Bench for s3_vertex_dispatcher: a queue model of the expected beat stream checked
// every cycle, plus directed descriptors with hand-computed endpoints.
module tb_s3_vertex_dispatcher;
  import gnn_part_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [ID_W-1:0]   base_ID;
  logic [CORE_W-1:0] core_cnt;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_ID;
  logic [CORE_W-1:0] out_core;
  logic              out_core_last;
  logic              out_last;
  logic              done;
  logic              busy;

  s3_vertex_dispatcher dut (
    .clk           (clk),
    .rst           (rst),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .base_ID       (base_ID),
    .core_cnt      (core_cnt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ID        (out_ID),
    .out_core      (out_core),
    .out_core_last (out_core_last),
    .out_last      (out_last),
    .done          (done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int id;
    int core;
    bit cl;
    bit l;
  } beat_t;

  beat_t q[$];
  int    m_state    = 0;  // 0 idle, 1 streaming, 2 done pulse
  int    beats_seen = 0;
  int    first_id   = -1;
  int    last_id    = -1;
  int    last_core  = -1;
  int    done_cnt   = 0;

  // Expected beat list straight from the range/clip rules.
  function automatic void build(input int base, input int cnt);
    beat_t b;
    int    vpc;
    vpc = 1 << LOG2_VPC;
    q.delete();
    if (cnt == 0 || base >= NUM_VERTICES) return;
    for (int c = 0; c < cnt; c++) begin
      for (int o = 0; o < vpc; o++) begin
        b.id   = base + c * vpc + o;
        b.core = c;
        b.cl   = (o == vpc - 1) || (b.id == NUM_VERTICES - 1);
        b.l    = ((c == cnt - 1) && (o == vpc - 1)) || (b.id == NUM_VERTICES - 1);
        q.push_back(b);
        if (b.id == NUM_VERTICES - 1) return;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_start_ready", start_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ID", out_ID, 0);
      chk("rst_out_core", out_core, 0);
      chk("rst_core_last", out_core_last, 0);
      chk("rst_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      m_state = 0;
      q.delete();
    end else begin
      chk("start_ready", start_ready, m_state == 0);
      chk("busy", busy, m_state != 0);
      chk("out_valid", out_valid, m_state == 1);
      chk("done", done, m_state == 2);
      if (done) done_cnt++;
      case (m_state)
        0: if (start_valid) begin
          build(int'(base_ID), int'(core_cnt));
          beats_seen = 0;
          first_id   = -1;
          m_state    = (q.size() == 0) ? 2 : 1;
        end
        1: begin
          if (q.size() == 0) begin
            chk("overrun", 1, 0);
            m_state = 2;
          end else begin
            chk("out_ID", out_ID, q[0].id);
            chk("out_core", out_core, q[0].core);
            chk("out_core_last", out_core_last, q[0].cl);
            chk("out_last", out_last, q[0].l);
            if (out_ready) begin
              beats_seen++;
              if (first_id < 0) first_id = int'(out_ID);
              last_id   = int'(out_ID);
              last_core = int'(out_core);
              m_state   = q[0].l ? 2 : 1;
              void'(q.pop_front());
            end
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic send(input int b, input int c);
    start_valid = 1'b1;
    base_ID     = ID_W'(b);
    core_cnt    = CORE_W'(c);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    base_ID     = '0;
    core_cnt    = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_start_ready", start_ready, 1);

    // Two full cores
    send(0, 2);
    wait_done(200);
    chk("t1_beats", beats_seen, 64);
    chk("t1_first", first_id, 0);
    chk("t1_last", last_id, 63);
    chk("t1_last_core", last_core, 1);

    // Clipped tail inside core 0
    send(3680, 2);
    wait_done(200);
    chk("t2_beats", beats_seen, 23);
    chk("t2_first", first_id, 3680);
    chk("t2_last", last_id, 3702);
    chk("t2_last_core", last_core, 0);

    // Zero-beat descriptors
    send(100, 0);
    wait_done(10);
    chk("t3a_beats", beats_seen, 0);
    send(4000, 3);
    wait_done(10);
    chk("t3b_beats", beats_seen, 0);
    chk("t3_ready_back", start_ready, 1);

    // Back-pressure pattern 1,0,0 repeating
    begin
      int d0;
      int k;
      d0 = done_cnt;
      out_ready = 1'b1;
      send(64, 1);
      k = 1;
      while (done_cnt == d0 && k < 400) begin
        out_ready = (k % 3 == 0);
        @(posedge clk); #1;
        k++;
      end
      if (done_cnt == d0) begin
        n_chk++;
        n_fail++;
        $display("FAIL t4_timeout: no done within 400 cycles");
      end
      out_ready = 1'b1;
    end
    chk("t4_beats", beats_seen, 32);
    chk("t4_first", first_id, 64);
    chk("t4_last", last_id, 95);

    // start_valid held through RUN; second descriptor waits for IDLE
    start_valid = 1'b1;
    base_ID     = ID_W'(0);
    core_cnt    = CORE_W'(1);
    @(posedge clk); #1;
    base_ID = ID_W'(128);
    wait_done(200);
    chk("t5a_beats", beats_seen, 32);
    chk("t5a_last", last_id, 31);
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_done(200);
    chk("t5b_beats", beats_seen, 32);
    chk("t5b_first", first_id, 128);
    chk("t5b_last", last_id, 159);

    // Reset in mid-stream, then a clean restart
    send(0, 2);
    begin
      int k;
      k = 0;
      while (beats_seen < 10 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk("t6_reached_10", beats_seen, 10);
    end
    rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_id", out_ID, 0);
    chk("t6_async_ready", start_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(200, 1);
    wait_done(200);
    chk("t6_beats", beats_seen, 32);
    chk("t6_first", first_id, 200);
    chk("t6_last", last_id, 231);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
